// File: rtl/controle_multiciclo_if.sv
// Control/datapath bundle for the multicycle MIPS controller: IR fields and ALU zero
// flag in, mux selects, strobes and ALU operation out.
interface controle_multiciclo_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] operation;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, operation, pc_source, illegal_op, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, operation, pc_source, illegal_op, state
   );
endinterface

// File: rtl/controle_multiciclo.sv
// Moore multicycle MIPS control FSM; addi support (states 10/11) is enabled by
// defining CONTROLE_ADDI_EN.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC + 4
// DECODE   | dispatch on opcode, precompute branch target
// MEMADR   | ALU computes A + imm for lw/sw
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write MDR into rt
// MEMWRITE | write B to memory at ALUOut
// EXECUTE  | R-type ALU op from funct
// ALUWB    | write ALUOut into rd
// BRANCH   | compare A - B, load PC from ALUOut on zero
// JUMP     | load PC with jump target
// ADDIEX   | ALU computes A + imm
// ADDIWB   | write ALUOut into rt
module controle_multiciclo (
   input  logic                        clk,
   input  logic                        reset,
   controle_multiciclo_if.master       bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDIEX   = 4'd10,
      ADDIWB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t     state_q, state_d;
   logic       is_sw;
   logic       funct_valid;
   logic [2:0] funct_op;
   logic       pc_write, branch, mem_rd, mem_wr, ir_wr, reg_wr, illegal;

   always_comb begin
      funct_valid = 1'b1;
      funct_op    = 3'b010;
      case (bus.funct)
         6'b100000: funct_op = 3'b010;
         6'b100010: funct_op = 3'b110;
         6'b100100: funct_op = 3'b000;
         6'b100101: funct_op = 3'b001;
         6'b101010: funct_op = 3'b111;
         default:   funct_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d        = FETCH;
      pc_write       = 1'b0;
      branch         = 1'b0;
      mem_rd         = 1'b0;
      mem_wr         = 1'b0;
      ir_wr          = 1'b0;
      reg_wr         = 1'b0;
      illegal        = 1'b0;
      bus.iord       = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.operation  = 3'b010;
      bus.pc_source  = 2'b00;
      case (state_q)
         FETCH: begin
            mem_rd        = 1'b1;
            ir_wr         = 1'b1;
            pc_write      = 1'b1;
            bus.alu_src_b = 2'b01;
            state_d       = DECODE;
         end
         DECODE: begin
            bus.alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         if (funct_valid) state_d = EXECUTE; else illegal = 1'b1;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
`ifdef CONTROLE_ADDI_EN
               OP_ADDI:      state_d = ADDIEX;
`endif
               default:      illegal = 1'b1;
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = is_sw ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            bus.iord = 1'b1;
            mem_rd   = 1'b1;
            state_d  = MEMWB;
         end
         MEMWB: begin
            bus.mem_to_reg = 1'b1;
            reg_wr         = 1'b1;
         end
         MEMWRITE: begin
            bus.iord = 1'b1;
            mem_wr   = 1'b1;
         end
         EXECUTE: begin
            bus.alu_src_a = 1'b1;
            bus.operation = funct_op;
            state_d       = ALUWB;
         end
         ALUWB: begin
            bus.reg_dst = 1'b1;
            reg_wr      = 1'b1;
         end
         BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.operation = 3'b110;
            bus.pc_source = 2'b01;
            branch        = 1'b1;
         end
         JUMP: begin
            bus.pc_source = 2'b10;
            pc_write      = 1'b1;
         end
`ifdef CONTROLE_ADDI_EN
         ADDIEX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = ADDIWB;
         end
         ADDIWB: begin
            reg_wr = 1'b1;
         end
`endif
         default: state_d = FETCH;
      endcase
   end

   // Store/load choice is latched in DECODE so MEMADR does not depend on opcode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         is_sw   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) is_sw <= (bus.opcode == OP_SW);
      end
   end

   assign bus.pc_en      = ~reset & (pc_write | (branch & bus.zero));
   assign bus.mem_read   = ~reset & mem_rd;
   assign bus.mem_write  = ~reset & mem_wr;
   assign bus.ir_write   = ~reset & ir_wr;
   assign bus.reg_write  = ~reset & reg_wr;
   assign bus.illegal_op = ~reset & illegal;
   assign bus.state      = state_q;
endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Moore-style multicycle control FSM for the MIPS datapath: the producer side of the ALU's `operation`/`zero` interface. It sequences fetch/decode/execute/memory/writeback, drives datapath mux selects and write enables, generates the 3-bit ALU `operation` code, and consumes the ALU's `zero` flag to resolve `beq`. It sits between the instruction register and the datapath.

## Interface
- Parameters: none; encodings are fixed below.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]. Valid from DECODE through the end of the instruction.
- `funct` in 6: IR[5:0]. Same validity as `opcode`.
- `zero` in 1: ALU zero flag, combinational from the current cycle's ALU result.
- `pc_en` out 1: PC load, `pc_write | (branch & zero)`.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: IR load.
- `reg_dst` out 1: destination register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback source. 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `operation` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (addi only when the configuration macro is defined).
- Supported R-type funct codes map to `operation`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
- States (4-bit) and asserted outputs. Every output not listed is 0; `operation` defaults to 010.
  - 0 FETCH: `mem_read`, `ir_write`, `alu_src_b`=01, `pc_write`. Next: DECODE.
  - 1 DECODE: `alu_src_b`=11. Next state by opcode:
    - lw, sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - j → JUMP
    - addi → ADDIEX
    - anything else → FETCH, with `illegal_op`=1 this cycle
  - 2 MEMADR: `alu_src_a`, `alu_src_b`=10. Next: MEMREAD for lw, MEMWRITE for sw.
  - 3 MEMREAD: `iord`, `mem_read`. Next: MEMWB.
  - 4 MEMWB: `mem_to_reg`, `reg_write`. Next: FETCH.
  - 5 MEMWRITE: `iord`, `mem_write`. Next: FETCH.
  - 6 EXECUTE: `alu_src_a`, `alu_src_b`=00, `operation` from funct. Next: ALUWB.
  - 7 ALUWB: `reg_dst`, `reg_write`. Next: FETCH.
  - 8 BRANCH: `alu_src_a`, `operation`=110, `pc_source`=01, branch. Next: FETCH.
  - 9 JUMP: `pc_source`=10, `pc_write`. Next: FETCH.
  - 10 ADDIEX: `alu_src_a`, `alu_src_b`=10. Next: ADDIWB.
  - 11 ADDIWB: `reg_write`. `reg_dst` and `mem_to_reg` stay 0. Next: FETCH.
- Unsupported funct on an R-type is illegal: it is caught in DECODE and treated like an unknown opcode.
- Encodings 12–15 are unreachable. If entered, the FSM goes to FETCH next cycle with all enables 0.

## Timing
- `state` is registered. All outputs are decoded from `state`, plus `zero` for `pc_en` and `opcode`/`funct` for `operation`, `illegal_op` and next-state.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2 (FETCH + DECODE).
- `pc_en` in BRANCH follows `zero` combinationally in the same cycle.
- Reset:
  - `reset`=1 at a rising edge sets `state` to FETCH (0).
  - While `reset` is high, `pc_en`, `mem_read`, `mem_write`, `ir_write`, `reg_write` and `illegal_op` are forced to 0.
  - The first real fetch is the first cycle with `reset` low.
  - Reset mid-instruction abandons it; nothing further is written.
- `opcode` and `funct` are ignored in every state other than DECODE and EXECUTE.

## Configuration
- `CONTROLE_ADDI_EN` defined: addi is supported, and states 10 and 11 exist.
- Not defined: opcode 001000 is illegal. DECODE goes to FETCH with `illegal_op`=1, and states 10/11 are treated as unreachable encodings.

## Test plan
- Reset: hold `reset` for 2 cycles, then release. Required: `state`=0 and all enables 0 during reset; FETCH outputs (`pc_en`=1, `ir_write`=1, `operation`=010) in the first cycle after release.
- lw, `opcode`=100011: `state` sequence 0,1,2,3,4,0. `iord`=1 only in state 3; `reg_write`=1 and `mem_to_reg`=1 only in state 4.
- R-type sub, funct 100010: `operation`=110 in EXECUTE. ALUWB has `reg_dst`=1 and `reg_write`=1. 4 cycles total.
- beq:
  - `zero`=1 in BRANCH → `pc_en`=1, `pc_source`=01.
  - Repeat with `zero`=0 → `pc_en`=0.
  - Both cases return to FETCH after 3 cycles.
- Illegal input: `opcode`=111111, then an R-type with funct 000000. Each gives a one-cycle `illegal_op` pulse in DECODE, returns to FETCH, and asserts no write enables.
- addi, `opcode`=001000:
  - With `CONTROLE_ADDI_EN` defined: sequence 0,1,10,11,0, with `alu_src_b`=10 and `operation`=010.
  - Without it: `illegal_op` pulse, then FETCH.
